// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC, issues
// fetches over a ready-handshaked instruction-memory port, and presents the
// fetched instruction to the decode stage through the IFID_* registers.
//
// A hazard-unit stall freezes IF/ID. A fetch that completes during a stall
// is parked in a one-entry skid buffer. A taken branch or jump resolved in
// ID redirects the PC and flushes IF/ID. If that redirect arrives while a
// fetch is still waiting on memory, the stale reply is dropped when it
// returns.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   stall           hazard-unit stall, holds IF/ID
//   redirect        taken branch/jump from ID
//   redirect_target new PC, valid with redirect
//   imem_req        fetch request
//   imem_addr       fetch address, always equal to pc
//   imem_ready      memory accepts the request and returns data this cycle
//   imem_rdata      instruction word, valid when imem_req && imem_ready
//   pc              current fetch PC
//   IFID_instr      instruction to ID, 0 (NOP) when not valid
//   IFID_pc_plus4   PC of the IF/ID instruction plus PC_STEP
//   IFID_valid      IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc_plus4,
  output logic        IFID_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        discard;
  logic [31:0] pend_target;
  logic        fire;
  logic [31:0] pc_next;

  // A full skid buffer means there is nowhere to put another reply, so the
  // request is withdrawn until the buffer drains. This also keeps a long
  // stall from generating further traffic.
  assign imem_req  = !rst && !skid_valid;
  assign fire      = imem_req && imem_ready;
  assign imem_addr = pc;
  // 32-bit modulo arithmetic, so the top of the address space wraps to 0.
  assign pc_next   = pc + STEP;

  // PC, IF/ID, skid buffer and pending-redirect state. The branches below
  // are evaluated in priority order: a redirect beats everything (including
  // stall), a reply belonging to a cancelled fetch is dropped next, then a
  // parked skid entry drains ahead of any new fetch. The PC only moves on a
  // completed handshake or a redirect, which keeps imem_addr stable while a
  // request is waiting on memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      IFID_instr    <= 32'h0;
      IFID_pc_plus4 <= 32'h0;
      IFID_valid    <= 1'b0;
      skid_valid    <= 1'b0;
      skid_instr    <= 32'h0;
      skid_pc4      <= 32'h0;
      discard       <= 1'b0;
      pend_target   <= 32'h0;
    end else if (redirect) begin
      IFID_valid <= 1'b0;
      IFID_instr <= 32'h0;
      skid_valid <= 1'b0;
      if (fire || skid_valid) begin
        // Nothing left in flight, so the new PC can take effect now.
        pc      <= redirect_target;
        discard <= 1'b0;
      end else begin
        // A request is still waiting; the address must stay put until it
        // completes, so remember the target and drop the reply later.
        // A later redirect in this window simply overwrites the target.
        discard     <= 1'b1;
        pend_target <= redirect_target;
      end
    end else if (fire && discard) begin
      pc      <= pend_target;
      discard <= 1'b0;
      if (!stall) begin
        IFID_valid <= 1'b0;
        IFID_instr <= 32'h0;
      end
    end else if (skid_valid && !stall) begin
      IFID_instr    <= skid_instr;
      IFID_pc_plus4 <= skid_pc4;
      IFID_valid    <= 1'b1;
      skid_valid    <= 1'b0;
    end else if (fire && !stall) begin
      IFID_instr    <= imem_rdata;
      IFID_pc_plus4 <= pc_next;
      IFID_valid    <= 1'b1;
      pc            <= pc_next;
    end else if (fire) begin
      skid_instr <= imem_rdata;
      skid_pc4   <= pc_next;
      skid_valid <= 1'b1;
      pc         <= pc_next;
    end else if (!stall) begin
      IFID_valid <= 1'b0;
      IFID_instr <= 32'h0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Scoreboard bench for if_stage. Each cycle the bench states what it drives
// and which fetch address it expects. When a fetch is expected to reach ID,
// its instruction and PC+4 are queued. Whenever ID consumes IF/ID (valid and
// not stalled), the head of the queue is popped and compared.
// ---------------------------------------------------------------------------
module tb_if_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pc_plus4;
  logic        IFID_valid;

  int     checks;
  int     errors;
  fetch_t exp_q[$];

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .IFID_instr     (IFID_instr),
    .IFID_pc_plus4  (IFID_pc_plus4),
    .IFID_valid     (IFID_valid)
  );

  // The instruction word at each address is a tag of that address, so a
  // misrouted fetch is visible in the data.
  function automatic logic [31:0] instr_at(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Combinational instruction memory.
  assign imem_rdata = instr_at(imem_addr);

  // Free-running clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check the fetch port, consume IF/ID if ID is
  // not stalled, update the scoreboard, then advance past the next edge.
  task automatic applyStimulus(input logic st, input logic rd,
                               input logic [31:0] tgt, input logic rdy,
                               input logic exp_req, input logic [31:0] exp_addr,
                               input logic deliver);
    fetch_t f;
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    imem_ready      = rdy;
    #1;
    checkOutput("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    checkOutput("pc", pc, exp_addr);
    if (exp_req) checkOutput("imem_addr", imem_addr, exp_addr);
    if (!IFID_valid) checkOutput("bubble_instr", IFID_instr, 32'h0);
    if (IFID_valid && !stall) begin
      checkOutput("sb_nonempty", {31'h0, exp_q.size() > 0}, 32'h1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        checkOutput("ifid_instr", IFID_instr, f.instr);
        checkOutput("ifid_pc_plus4", IFID_pc_plus4, f.pc4);
      end
    end
    if (rd) exp_q.delete();
    if (deliver) begin
      f.instr = instr_at(exp_addr);
      f.pc4   = exp_addr + 32'd4;
      exp_q.push_back(f);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    imem_ready      = 1'b1;
    #1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'h0, IFID_valid}, 32'h0);
    checkOutput("rst_instr", IFID_instr, 32'h0);
    checkOutput("rst_pc4", IFID_pc_plus4, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sequential fetch 0, 4, then two memory wait cycles at 0x8.
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0004, 1);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0008, 0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0008, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0008, 1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_000C, 1);

    // Stall raised as 0x10 fires; the reply goes to the skid buffer.
    applyStimulus(1, 0, 32'h0, 1, 1, 32'h0000_0010, 1);
    checkOutput("stall_hold_pc4", IFID_pc_plus4, 32'h0000_0010);
    checkOutput("stall_hold_valid", {31'h0, IFID_valid}, 32'h1);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0000_0014, 0);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h0000_0014, 0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0000_0014, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0014, 1);

    // Redirect to 0x40 while 0x18 is outstanding; its reply is dropped.
    applyStimulus(0, 1, 32'h0000_0040, 0, 1, 32'h0000_0018, 0);
    checkOutput("redir_flush_valid", {31'h0, IFID_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0018, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0018, 0);
    checkOutput("dropped_valid", {31'h0, IFID_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0040, 1);

    // Fill the skid, then redirect to 0x80 while still stalled.
    applyStimulus(1, 0, 32'h0, 1, 1, 32'h0000_0044, 1);
    applyStimulus(1, 1, 32'h0000_0080, 1, 0, 32'h0000_0048, 0);
    checkOutput("skid_redir_valid", {31'h0, IFID_valid}, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0080, 1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0084, 1);

    // Redirect with 0x88 outstanding, then reset between clock edges.
    applyStimulus(0, 1, 32'h0000_0100, 0, 1, 32'h0000_0088, 0);
    redirect = 1'b0;
    #2;
    checkOutput("pre_rst_addr", imem_addr, 32'h0000_0088);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pc", pc, 32'h0);
    checkOutput("async_rst_valid", {31'h0, IFID_valid}, 32'h0);
    checkOutput("async_rst_req", {31'h0, imem_req}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the first reply must be kept, i.e. discard was cleared.
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0004, 1);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0008, 0);

    // Redirect with a completing fetch, then wrap past the top of memory.
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1, 1, 32'h0000_0008, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'hFFFF_FFF8, 1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 1);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0004, 0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_0004, 0);

    checkOutput("sb_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
